apu_status_read: RTL and testbench

// Read side of the APU memory-mapped register file; services CPU reads of $4015 (status).

---
 rtl/apu_pkg.sv | 20 ++
 rtl/apu_irq_flag.sv | 32 +++
 rtl/apu_status_read.sv | 98 +++++++++
 tb/tb_apu_status_read.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants and the status-byte layout for the APU $4015 read path.
// Bit positions of the status struct match the localparams below.
package apu_pkg;

  localparam logic [4:0] STATUS_ADDR = 5'h15;
  localparam logic [4:0] FRAME_ADDR  = 5'h17;

  localparam int ST_DMC_IRQ   = 7;
  localparam int ST_FRAME_IRQ = 6;
  localparam int ST_DMC_ACT   = 4;

  typedef struct packed {
    logic       dmcIrq;
    logic       frameIrq;
    logic       openBus5;
    logic       dmcActive;
    logic [3:0] lengthNonzero;
  } apu_status_t;

endpackage

// File: rtl/apu_irq_flag.sv
// Sticky interrupt flag with set/clear inputs, updated only on enabled cycles.
// SET_WINS picks which input dominates when both arrive together.
module apu_irq_flag #(
  parameter bit SET_WINS = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en_i,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clk_en_i) begin
      if (SET_WINS) flag_d = set_i | (flag_q & ~clr_i);
      else          flag_d = ~clr_i & (set_i | flag_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/apu_status_read.sv
// Read side of the APU register file: serves $4015 status reads, owns the frame/DMC
// interrupt flags and the frame IRQ inhibit bit, and drives the APU IRQ line.
module apu_status_read #(
  parameter logic [4:0] STATUS_ADDR = apu_pkg::STATUS_ADDR,
  parameter logic [4:0] FRAME_ADDR  = apu_pkg::FRAME_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_clk_en,
  input  logic [4:0] reg_addr,
  input  logic       reg_en,
  input  logic       reg_we,
  input  logic [7:0] reg_wdata,
  input  logic [7:0] open_bus_data,
  input  logic [3:0] length_nonzero,
  input  logic       dmc_active,
  input  logic       frame_irq_set,
  input  logic       dmc_irq_set,
  output logic [7:0] reg_rdata,
  output logic       reg_rvalid,
  output logic       irq
);

  import apu_pkg::*;

  logic        readAcc, writeAcc;
  logic        statusRead, statusWrite, frameWrite, inhibitWrite;
  logic        frameIrq, dmcIrq;
  logic        irqInhibit_q, irqInhibit_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  apu_status_t status;
  logic        unusedWdata;

  assign readAcc      = cpu_clk_en & reg_en & ~reg_we;
  assign writeAcc     = cpu_clk_en & reg_en & reg_we;
  assign statusRead   = readAcc & (reg_addr == STATUS_ADDR);
  assign statusWrite  = writeAcc & (reg_addr == STATUS_ADDR);
  assign frameWrite   = writeAcc & (reg_addr == FRAME_ADDR);
  assign inhibitWrite = frameWrite & reg_wdata[6];
  assign unusedWdata  = ^{reg_wdata[7], reg_wdata[5:0]};

  // An inhibiting $4017 write beats a coincident frame IRQ; a $4015 read loses to it.
  apu_irq_flag #(.SET_WINS(1'b1)) u_frame_flag (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (cpu_clk_en),
    .set_i    (frame_irq_set & ~irqInhibit_q & ~inhibitWrite),
    .clr_i    (statusRead | inhibitWrite),
    .flag_o   (frameIrq)
  );

  apu_irq_flag #(.SET_WINS(1'b1)) u_dmc_flag (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (cpu_clk_en),
    .set_i    (dmc_irq_set),
    .clr_i    (statusWrite),
    .flag_o   (dmcIrq)
  );

  always_comb begin
    status.dmcIrq        = dmcIrq;
    status.frameIrq      = frameIrq;
    status.openBus5      = open_bus_data[5];
    status.dmcActive     = dmc_active;
    status.lengthNonzero = length_nonzero;
  end

  always_comb begin
    irqInhibit_d = irqInhibit_q;
    rdata_d      = rdata_q;
    rvalid_d     = rvalid_q;
    if (frameWrite) irqInhibit_d = reg_wdata[6];
    // Flags are captured from the flops, so a read sees them before its own clear lands.
    if (cpu_clk_en) begin
      rvalid_d = readAcc;
      if (readAcc) rdata_d = (reg_addr == STATUS_ADDR) ? status : open_bus_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irqInhibit_q <= 1'b0;
      rdata_q      <= 8'h00;
      rvalid_q     <= 1'b0;
    end else begin
      irqInhibit_q <= irqInhibit_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = frameIrq | dmcIrq;

endmodule

// File: tb/tb_apu_status_read.sv
// Scenario-per-task bench for apu_status_read; read expectations are queued when a
// read is issued and popped when the registered response appears.
module tb_apu_status_read;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_clk_en;
  logic [4:0] reg_addr;
  logic       reg_en;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic [7:0] open_bus_data;
  logic [3:0] length_nonzero;
  logic       dmc_active;
  logic       frame_irq_set;
  logic       dmc_irq_set;
  logic [7:0] reg_rdata;
  logic       reg_rvalid;
  logic       irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] expQ[$];
  logic [7:0] exp;

  always #5 clk = ~clk;

  apu_status_read dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_clk_en     (cpu_clk_en),
    .reg_addr       (reg_addr),
    .reg_en         (reg_en),
    .reg_we         (reg_we),
    .reg_wdata      (reg_wdata),
    .open_bus_data  (open_bus_data),
    .length_nonzero (length_nonzero),
    .dmc_active     (dmc_active),
    .frame_irq_set  (frame_irq_set),
    .dmc_irq_set    (dmc_irq_set),
    .reg_rdata      (reg_rdata),
    .reg_rvalid     (reg_rvalid),
    .irq            (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busRead(input logic [4:0] a);
    reg_addr = a; reg_en = 1'b1; reg_we = 1'b0;
    tick();
    reg_en = 1'b0;
  endtask

  task automatic busWrite(input logic [4:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_en = 1'b1; reg_we = 1'b1;
    tick();
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic pulseFrame();
    frame_irq_set = 1'b1; tick(); frame_irq_set = 1'b0;
  endtask

  task automatic pulseDmc();
    dmc_irq_set = 1'b1; tick(); dmc_irq_set = 1'b0;
  endtask

  task automatic clearInputs();
    open_bus_data = 8'h00; length_nonzero = 4'h0; dmc_active = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=00", reg_rdata); end
    total++; if (reg_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid got=%b want=0", reg_rvalid); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b want=0", irq); end
    rst = 1'b0; tick();
  endtask

  task automatic test_status_read();
    length_nonzero = 4'b0101; dmc_active = 1'b1; open_bus_data = 8'h20;
    expQ.push_back(8'h35);
    busRead(5'h15);
    total++; if (reg_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL status_rvalid got=%b want=1", reg_rvalid); end
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL status_rdata got=%h want=%h", reg_rdata, exp); end
    tick();
    total++; if (reg_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL status_rvalid_drop got=%b want=0", reg_rvalid); end
    total++; if (reg_rdata !== 8'h35) begin bad++; $display("[TB] FAIL status_rdata_hold got=%h want=35", reg_rdata); end
    clearInputs();
  endtask

  task automatic test_back_to_back();
    pulseFrame();
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL frame_irq_up got=%b want=1", irq); end
    expQ.push_back(8'h40);
    busRead(5'h15);
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL b2b_first got=%h want=%h", reg_rdata, exp); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL frame_irq_cleared got=%b want=0", irq); end
    expQ.push_back(8'h00);
    busRead(5'h15);
    total++; if (reg_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_rvalid got=%b want=1", reg_rvalid); end
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL b2b_second got=%h want=%h", reg_rdata, exp); end
    tick();
  endtask

  task automatic test_inhibit();
    busWrite(5'h17, 8'h40);
    total++; if (reg_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL write_no_rvalid got=%b want=0", reg_rvalid); end
    pulseFrame();
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL inhibit_irq got=%b want=0", irq); end
    expQ.push_back(8'h00);
    busRead(5'h15);
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL inhibit_read got=%h want=%h", reg_rdata, exp); end
    busWrite(5'h17, 8'h00);
    pulseFrame();
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL uninhibit_irq got=%b want=1", irq); end
    // Same-cycle frame set with inhibiting $4017 write: cleared.
    frame_irq_set = 1'b1;
    busWrite(5'h17, 8'h40);
    frame_irq_set = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL inhibit_same_cycle got=%b want=0", irq); end
    busWrite(5'h17, 8'h00);
  endtask

  task automatic test_dmc();
    pulseDmc();
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL dmc_irq_up got=%b want=1", irq); end
    expQ.push_back(8'h80);
    busRead(5'h15);
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL dmc_read1 got=%h want=%h", reg_rdata, exp); end
    expQ.push_back(8'h80);
    busRead(5'h15);
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL dmc_read2 got=%h want=%h", reg_rdata, exp); end
    busWrite(5'h15, 8'h00);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL dmc_write_clear got=%b want=0", irq); end
    total++; if (reg_rdata !== 8'h80) begin bad++; $display("[TB] FAIL rdata_hold_write got=%h want=80", reg_rdata); end
    dmc_irq_set = 1'b1;
    busWrite(5'h15, 8'h00);
    dmc_irq_set = 1'b0;
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL dmc_set_wins got=%b want=1", irq); end
    busWrite(5'h15, 8'h00);
  endtask

  task automatic test_coincident();
    frame_irq_set = 1'b1;
    expQ.push_back(8'h00);
    busRead(5'h15);
    frame_irq_set = 1'b0;
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL coincide_rdata got=%h want=%h", reg_rdata, exp); end
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL coincide_flag got=%b want=1", irq); end
    expQ.push_back(8'h40);
    busRead(5'h15);
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL coincide_reread got=%h want=%h", reg_rdata, exp); end
    tick();
  endtask

  task automatic test_clk_en();
    cpu_clk_en = 1'b0;
    frame_irq_set = 1'b1;
    busRead(5'h15);
    frame_irq_set = 1'b0;
    total++; if (reg_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL clken_rvalid got=%b want=0", reg_rvalid); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL clken_irq got=%b want=0", irq); end
    cpu_clk_en = 1'b1;
  endtask

  task automatic test_open_bus();
    open_bus_data = 8'hA5;
    expQ.push_back(8'hA5);
    busRead(5'h00);
    total++; if (reg_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL openbus_rvalid got=%b want=1", reg_rvalid); end
    exp = expQ.pop_front();
    total++; if (reg_rdata !== exp) begin bad++; $display("[TB] FAIL openbus_rdata got=%h want=%h", reg_rdata, exp); end
  endtask

  task automatic test_reset_mid();
    pulseFrame();
    pulseDmc();
    reg_addr = 5'h15; reg_en = 1'b1; reg_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    expQ.delete();
    total++; if ({reg_rdata, reg_rvalid, irq} !== 10'b0) begin bad++; $display("[TB] FAIL midreset_outputs got=%h/%b/%b want=00/0/0", reg_rdata, reg_rvalid, irq); end
    tick();
    reg_en = 1'b0;
    rst = 1'b0;
    tick();
    total++; if ({reg_rdata, reg_rvalid, irq} !== 10'b0) begin bad++; $display("[TB] FAIL postreset_outputs got=%h/%b/%b want=00/0/0", reg_rdata, reg_rvalid, irq); end
    total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_leftover got=%0d want=0", expQ.size()); end
  endtask

  initial begin
    rst = 1'b1; cpu_clk_en = 1'b1; reg_addr = 5'h00; reg_en = 1'b0; reg_we = 1'b0;
    reg_wdata = 8'h00; frame_irq_set = 1'b0; dmc_irq_set = 1'b0;
    clearInputs();
    test_reset();
    test_status_read();
    test_back_to_back();
    test_inhibit();
    test_dmc();
    test_coincident();
    test_clk_en();
    test_open_bus();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
